// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the writeback-stage memory port arbiter.
package mem_arb_pkg;

  localparam int VEC_SIZE = 4;
  localparam int REG_SIZE = 8;

  typedef logic [VEC_SIZE*REG_SIZE-1:0] vec_word_t;

  typedef enum logic [1:0] {
    PIPE_PRIO   = 2'd0,
    HOST_FORCED = 2'd1,
    HOST_LOCKED = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_PIPE = 2'd1;
  localparam logic [1:0] OWNER_HOST = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at LIMIT, never wraps.
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             atLimit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign atLimit = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between pipeline (priority) and host loader,
// with starvation-forced host grants and a bounded host burst lock.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int maxWait      = 4,
  parameter int maxLock      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pipeReq,
  input  logic                             pipeWe,
  input  logic [registerSize-1:0]          pipeAddr,
  input  logic [vecSize*registerSize-1:0]  pipeWData,
  output logic                             pipeGrant,
  output logic                             pipeStall,
  output logic                             pipeRValid,
  input  logic                             hostReq,
  input  logic                             hostWe,
  input  logic [registerSize-1:0]          hostAddr,
  input  logic [vecSize*registerSize-1:0]  hostWData,
  input  logic                             hostLock,
  output logic                             hostGrant,
  output logic                             hostRValid,
  output logic                             memWriteEnable,
  output logic [registerSize-1:0]          memAddress,
  output logic [vecSize*registerSize-1:0]  memWriteData,
  input  logic [vecSize*registerSize-1:0]  memReadData,
  output logic [vecSize*registerSize-1:0]  rData
);

  localparam int WAIT_W = $clog2(maxWait + 1);
  localparam int LOCK_W = $clog2(maxLock + 1);

  arb_state_t        state, stateNext;
  logic [1:0]        owner;
  logic              hostGranted;
  logic              waitInc, lockInc;
  logic [WAIT_W-1:0] waitCnt;
  logic [LOCK_W-1:0] lockCnt;
  logic              waitAtLimit, lockAtLimit;
  logic              waitLast, lockLast;
  logic              pipeRValidQ, hostRValidQ;

  // "Last" means the step taken this cycle lands the counter on its limit.
  assign waitLast = (waitCnt == WAIT_W'(maxWait - 1));
  assign lockLast = (lockCnt >= LOCK_W'(maxLock - 1));

  always_comb begin
    owner = OWNER_NONE;
    unique case (state)
      PIPE_PRIO: begin
        if (pipeReq)      owner = OWNER_PIPE;
        else if (hostReq) owner = OWNER_HOST;
      end
      HOST_FORCED, HOST_LOCKED: begin
        if (hostReq) owner = OWNER_HOST;
      end
      default: owner = OWNER_NONE;
    endcase
    if (reset) owner = OWNER_NONE;
  end

  assign hostGranted = (owner == OWNER_HOST);
  assign waitInc     = (state == PIPE_PRIO) && hostReq && !hostGranted;

  always_comb begin
    stateNext = state;
    unique case (state)
      PIPE_PRIO: begin
        if (waitInc && (waitLast || waitAtLimit))
          stateNext = HOST_FORCED;
        else if (hostGranted && hostLock && !lockLast)
          stateNext = HOST_LOCKED;
      end
      HOST_FORCED: begin
        if (hostGranted && hostLock && !lockLast) stateNext = HOST_LOCKED;
        else                                      stateNext = PIPE_PRIO;
      end
      HOST_LOCKED: begin
        if (!hostLock || lockLast || lockAtLimit) stateNext = PIPE_PRIO;
      end
      default: stateNext = PIPE_PRIO;
    endcase
  end

  // The lock counter runs exactly while the next cycle is locked, so the
  // granting cycle counts as the first owned cycle of the burst.
  assign lockInc = (stateNext == HOST_LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PIPE_PRIO;
      pipeRValidQ <= 1'b0;
      hostRValidQ <= 1'b0;
    end else begin
      state       <= stateNext;
      pipeRValidQ <= (owner == OWNER_PIPE) && !pipeWe;
      hostRValidQ <= (owner == OWNER_HOST) && !hostWe;
    end
  end

  sat_counter #(.WIDTH(WAIT_W), .LIMIT(maxWait)) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (waitInc),
    .clear  (!waitInc),
    .count  (waitCnt),
    .atLimit(waitAtLimit)
  );

  sat_counter #(.WIDTH(LOCK_W), .LIMIT(maxLock)) u_lock_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (lockInc),
    .clear  (!lockInc),
    .count  (lockCnt),
    .atLimit(lockAtLimit)
  );

  always_comb begin
    memWriteEnable = 1'b0;
    memAddress     = '0;
    memWriteData   = '0;
    unique case (owner)
      OWNER_PIPE: begin
        memWriteEnable = pipeWe;
        memAddress     = pipeAddr;
        memWriteData   = pipeWData;
      end
      OWNER_HOST: begin
        memWriteEnable = hostWe;
        memAddress     = hostAddr;
        memWriteData   = hostWData;
      end
      default: ;
    endcase
  end

  assign pipeGrant  = (owner == OWNER_PIPE);
  assign hostGrant  = hostGranted;
  assign pipeStall  = pipeReq && !pipeGrant;
  // A reset arriving right after a read squashes the strobe it would show.
  assign pipeRValid = pipeRValidQ && !reset;
  assign hostRValid = hostRValidQ && !reset;
  assign rData      = memReadData;

endmodule
